// File: rtl/getir_pkg.sv
// getir_pkg: shared constants and the packed fetch-entry type for the
// getir_birimi instruction fetch stage.
package getir_pkg;

    localparam int                  DEF_XLEN     = 32;
    localparam int                  DEF_ILEN     = 32;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instructions.
    localparam int                  PC_STEP      = 4;

    // One buffered fetch result: instruction word with the PC it came from.
    typedef struct packed {
        logic [DEF_ILEN-1:0] instr;
        logic [DEF_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/getir_fifo.sv
// getir_fifo: small synchronous FIFO holding fetched entries toward decode.
// Registered write (no bypass), combinational head read, flush clears all
// entries in one cycle and wins over a simultaneous push or pop.
module getir_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop: never pop empty, never push into a full FIFO unless it also drains.
    always_comb begin
        do_pop  = pop && (level != '0);
        do_push = push && ((level != CW'(DEPTH)) || do_pop);
    end

    // Pointer and fill-level bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head presentation and occupancy outputs.
    always_comb begin
        head      = mem[rd_ptr];
        not_empty = (level != '0);
        count     = level;
    end

endmodule

// File: rtl/getir_birimi.sv
// getir_birimi: instruction fetch stage. Issues sequential fetch addresses
// over a valid/ready request channel, takes in-order responses of any
// latency, and buffers {instr, pc} toward decode. A redirect flushes the
// buffer and discards every response still owed for older requests.
// Optional feature macro: GETIR_HIZALAMA_EN (misaligned-redirect detection
// with a sticky misalign_o flag that suppresses requests).
module getir_birimi
    import getir_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              ILEN     = DEF_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            resp_valid_i,
    input  logic [ILEN-1:0] resp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
`ifdef GETIR_HIZALAMA_EN
    ,
    output logic            misalign_o
`endif
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            EW      = ILEN + XLEN;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   live;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            resp_keep;
    logic            pop;
    logic            misaligned;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head;
    logic            fifo_nonempty;

`ifdef GETIR_HIZALAMA_EN
    // Sticky misalignment flag: set by an unaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misaligned <= 1'b0;
        end else if (redirect_i) begin
            misaligned <= (redirect_pc_i[1:0] != 2'b00);
        end else begin
            misaligned <= misaligned;
        end
    end

    assign target     = redirect_pc_i;
    assign misalign_o = misaligned;
`else
    assign target     = redirect_pc_i & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    // Credit rule: live requests plus buffered entries never exceed the FIFO depth.
    always_comb begin
        live        = outstanding - drop;
        credit_used = {1'b0, live} + {1'b0, count};
        if (rst_i || misaligned) begin
            req_valid_o = 1'b0;
        end else begin
            req_valid_o = (credit_used < DEPTH_W);
        end
        req_addr_o = pc;
    end

    // Handshake decode; a redirect cycle discards the incoming response and ignores pop.
    always_comb begin
        req_fire         = req_valid_o && req_ready_i;
        resp_keep        = resp_valid_i && (drop == '0) && !redirect_i;
        pop              = fifo_nonempty && instr_ready_i && !redirect_i;
        outstanding_next = outstanding + CW'(req_fire) - CW'(resp_valid_i);
        push_data        = {resp_data_i, resp_pc};
    end

    // PC, response-PC, in-flight and discard bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                pc      <= target;
                resp_pc <= target;
                drop    <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + XLEN'(PC_STEP);
                end else begin
                    pc <= pc;
                end
                if (resp_valid_i && (drop != '0)) begin
                    drop    <= drop - CW'(1);
                    resp_pc <= resp_pc;
                end else if (resp_valid_i) begin
                    drop    <= drop;
                    resp_pc <= resp_pc + XLEN'(PC_STEP);
                end else begin
                    drop    <= drop;
                    resp_pc <= resp_pc;
                end
            end
        end
    end

    getir_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (resp_keep),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .not_empty (fifo_nonempty),
        .count     (count)
    );

    // Present the FIFO head to decode.
    always_comb begin
        instr_valid_o         = fifo_nonempty;
        {instr_o, instr_pc_o} = head;
    end

endmodule

// File: tb/tb_getir_birimi.sv
// tb_getir_birimi: randomized self-checking bench for getir_birimi.
// Reference model: the decode stream is consecutive PCs from the last
// redirect/reset target, each carrying mem_word(pc); requested addresses
// are consecutive from the same target; req_valid is allowed exactly when
// fewer than DEPTH requests issued since the target remain unpopped.
`timescale 1ns/1ps
module tb_getir_birimi;

    localparam int          XLEN   = 32;
    localparam int          ILEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_valid_o;
    logic        req_ready;
    logic [31:0] req_addr_o;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        instr_valid_o;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
`ifdef GETIR_HIZALAMA_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    getir_birimi #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready),
        .req_addr_o    (req_addr_o),
        .resp_valid_i  (resp_valid),
        .resp_data_i   (resp_data),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
`ifdef GETIR_HIZALAMA_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    // Knobs
    int          ready_pct  = 100;
    int          iready_pct = 100;
    int          lat_min    = 1;
    int          lat_max    = 1;
    bit          do_redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    // Model state
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    bit          misal;
    int          cyc;
    int          pops;
    int          first_pop_cyc;
    bit          arm_first;
    logic [31:0] seen_first_pc;

    function automatic bit exp_req_valid();
        return !misal && (((exp_req - exp_pc) >> 2) < 32'(DEPTH));
    endfunction

    task automatic cycle();
        bit          hs;
        bit          pp;
        bit          rv;
        logic [31:0] tgt;
        @(negedge clk);
        req_ready   = ($urandom_range(99) < ready_pct);
        instr_ready = ($urandom_range(99) < iready_pct);
        redirect    = do_redirect;
        redirect_pc = redirect_target;
        do_redirect = 1'b0;
        rv          = (mq.size() > 0) && (mq[0].due <= cyc);
        resp_valid  = rv;
        resp_data   = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        check("req_valid", req_valid_o, exp_req_valid());
`ifdef GETIR_HIZALAMA_EN
        check("misalign", misalign_o, misal);
`endif
        if (req_valid_o) check("req_addr", req_addr_o, exp_req);
        hs = req_valid_o && req_ready;
        pp = instr_valid_o && instr_ready && !redirect;
        if (pp) begin
            check("instr_pc", instr_pc_o, exp_pc);
            check("instr", instr_o, mem_word(exp_pc));
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (arm_first) begin
                seen_first_pc = instr_pc_o;
                arm_first     = 1'b0;
            end
        end
        if (rv) void'(mq.pop_front());
        if (hs) mq.push_back('{addr: req_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
        if (redirect) begin
            tgt = redirect_pc;
`ifdef GETIR_HIZALAMA_EN
            misal = (tgt[1:0] != 2'b00);
`else
            tgt[1:0] = 2'b00;
`endif
            exp_req = tgt;
            exp_pc  = tgt;
        end else begin
            if (hs) exp_req = exp_req + 32'd4;
            if (pp) exp_pc  = exp_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        req_ready   = 1'b0;
        instr_ready = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        #1;
        check("rst_req_valid", req_valid_o, 1'b0);
        check("rst_instr_valid", instr_valid_o, 1'b0);
`ifdef GETIR_HIZALAMA_EN
        check("rst_misalign", misalign_o, 1'b0);
`endif
        mq.delete();
        exp_req       = RST_PC;
        exp_pc        = RST_PC;
        misal         = 1'b0;
        cyc           = 0;
        pops          = 0;
        first_pop_cyc = -1;
        arm_first     = 1'b0;
        rst           = 1'b0;
    endtask

    // Redirect, then watch for the first instruction delivered afterwards.
    task automatic redirect_and_expect(input string tag, input logic [31:0] t, input logic [31:0] first_pc);
        do_redirect     = 1'b1;
        redirect_target = t;
        cycle();
        arm_first       = 1'b1;
        seen_first_pc   = 32'h0000_0001;
        for (int i = 0; i < 30 && arm_first; i++) cycle();
        check(tag, seen_first_pc, first_pc);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Sequential fetch with single-cycle memory and decode always ready.
        for (int i = 0; i < 12; i++) cycle();
        check("first_pop_cycle", first_pop_cyc, 2);
        check("throughput_pops", pops, 10);

        // Decode stall: buffer fills to DEPTH and requests stop.
        iready_pct = 0;
        for (int i = 0; i < 10; i++) cycle();
        @(posedge clk); #1;
        check("stall_req_valid", req_valid_o, 1'b0);
        check("stall_instr_valid", instr_valid_o, 1'b1);
        ready_pct  = 0;
        iready_pct = 100;
        pops       = 0;
        for (int i = 0; i < 8; i++) cycle();
        check("stall_buffered", pops, DEPTH);
        ready_pct = 100;
        for (int i = 0; i < 8; i++) cycle();

        // Redirect with three requests outstanding at 3-cycle latency.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 10 && mq.size() < 3; i++) cycle();
        check("outstanding3", mq.size(), 3);
        redirect_and_expect("redir_first_pc", 32'h0000_0100, 32'h0000_0100);
        for (int i = 0; i < 10; i++) cycle();

        // Redirect coinciding with a request handshake and a response.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 6; i++) cycle();
        do_redirect     = 1'b1;
        redirect_target = 32'h0000_0300;
        cycle();
        @(posedge clk); #1;
        check("redir_n1_instr_valid", instr_valid_o, 1'b0);
        check("redir_n1_addr", req_addr_o, 32'h0000_0300);
        arm_first     = 1'b1;
        seen_first_pc = 32'h0000_0001;
        for (int i = 0; i < 20 && arm_first; i++) cycle();
        check("same_cycle_first_pc", seen_first_pc, 32'h0000_0300);

        // PC wraps from the top of the address space to zero.
        do_redirect     = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        cycle();
        @(posedge clk); #1;
        check("wrap_addr", req_addr_o, 32'h0000_0000);
        for (int i = 0; i < 8; i++) cycle();

`ifdef GETIR_HIZALAMA_EN
        // Unaligned redirect sets the sticky flag and blocks requests.
        do_redirect     = 1'b1;
        redirect_target = 32'h0000_0102;
        cycle();
        @(posedge clk); #1;
        check("misalign_set", misalign_o, 1'b1);
        check("misalign_no_req", req_valid_o, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        redirect_and_expect("misalign_clear_first_pc", 32'h0000_0200, 32'h0000_0200);
        check("misalign_cleared", misalign_o, 1'b0);
`endif

        // Randomized traffic with occasional redirects.
        ready_pct  = 70;
        iready_pct = 70;
        lat_min    = 1;
        lat_max    = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                logic [31:0] t;
                if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
                else t = $urandom & 32'h0000_FFFC;
`ifdef GETIR_HIZALAMA_EN
                if ($urandom_range(7) == 0) t[1:0] = 2'b10;
`else
                t[1:0] = 2'($urandom);
`endif
                do_redirect     = 1'b1;
                redirect_target = t;
            end
            cycle();
        end

        // Reset in the middle of traffic, then resume.
        do_reset();
        for (int i = 0; i < 300; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
